mul_booth_seq: RTL and testbench
================================

# mul_booth_seq

Sequential radix-2 Booth multiplier for the datapath's MUL instruction: 32×32 signed operands, 64-bit product split into HI/LO. It holds no adder of its own. Each cycle it drives the operands of the shared 32-bit carry-lookahead adder and consumes that adder's sum and carry-out, so it sits directly upstream of the adder.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Fixed to match the adder; other values are unsupported.

Ports:
- `clock`, in, 1: rising-edge clock.
- `clear_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a multiply. Sampled in IDLE or DONE.
- `a`, in, 32: multiplicand, signed, captured at accept.
- `b`, in, 32: multiplier, signed, captured at accept.
- `add_a`, out, 32: adder operand A. Always equals the HI accumulator.
- `add_b`, out, 32: adder operand B. One of 0, M, or ~M.
- `add_cin`, out, 1: adder carry-in. 1 only for subtract.
- `add_z`, in, 32: adder sum.
- `add_cout`, in, 1: adder carry-out.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse when the product is valid.
- `hi`, out, 32: product bits [63:32].
- `lo`, out, 32: product bits [31:0].
- `abort`, in, 1: present only with `MUL_ABORT_EN`.

## Operation
- **Registers:**
  - M: multiplicand, 32 bits.
  - HI accumulator: 32 bits, drives `hi`.
  - Q: 32 bits, drives `lo`.
  - q_1: 1 bit.
  - count: 5 bits.
  - state: IDLE, RUN or DONE.
- **Reset:** while `clear_n` is low:
  - state = IDLE;
  - M, HI, Q, q_1 and count = 0;
  - `hi` = `lo` = 0;
  - `busy` = `done` = 0;
  - `add_b` = 0, `add_cin` = 0.
- **Accept:** on a rising edge with state ∈ {IDLE, DONE} and `start` = 1:
  - M ← `a`, Q ← `b`, HI ← 0, q_1 ← 0, count ← 0;
  - state → RUN.
  - `start` in RUN is ignored.
- **Recode:** each RUN cycle, combinationally on {Q[0], q_1}:
  - 00 or 11: `add_b` = 0, `add_cin` = 0.
  - 01: `add_b` = M, `add_cin` = 0 (add).
  - 10: `add_b` = ~M, `add_cin` = 1 (subtract).
  - Outside RUN, `add_b` = 0 and `add_cin` = 0.
- **True sign:** s = `add_a`[31] ^ `add_b`[31] ^ `add_cout`. This is the 33rd bit of the exact sum, and it makes overflow harmless, including M = 0x80000000.
- **Iteration:** at each RUN edge, shift {s, `add_z`, Q, q_1} arithmetically right by one:
  - HI ← {s, `add_z`[31:1]};
  - Q ← {`add_z`[0], Q[31:1]};
  - q_1 ← Q[0];
  - count ← count + 1.
- **RUN exit:** when count = 31 at the edge, state → DONE.
- **DONE:** `done` = 1 and `busy` = 0.
  - Next edge: → RUN if `start` = 1, otherwise → IDLE.
  - `hi` and `lo` hold the product until the next accept. They are not cleared on return to IDLE.

## Timing
- Start is accepted at edge E0. `busy` is high from E0 to E32, i.e. exactly 32 cycles.
- Iterations occur at E1 through E32. The product is valid in `hi`/`lo` after E32.
- `done` is high for exactly the one cycle between E32 and E33.
- Back-to-back: `start` held high during DONE is accepted at E33. There is no idle gap, and `done` does not repeat until E65.
- Combinational path per cycle: Q[0], q_1 → `add_b`/`add_cin` → external adder → `add_z`/`add_cout` → HI/Q. The adder is outside this block but inside its cycle budget.
- `clear_n` asserted mid-RUN: immediate return to IDLE with all registers zeroed. No `done` pulse; any partial result is discarded.

## Configuration
- **`MUL_ABORT_EN` defined:**
  - The `abort` input exists.
  - `abort` = 1 at a RUN edge forces state → IDLE, with HI, Q, q_1 and count cleared to 0 and no `done` pulse.
  - `abort` takes priority over the count = 31 exit.
  - `abort` outside RUN has no effect.
- **`MUL_ABORT_EN` undefined:** the `abort` port is absent, and RUN always completes 32 iterations unless `clear_n` is asserted.

## Test plan
- `a` = 3, `b` = 5, pulse `start` → `done` exactly 32 cycles after accept; `hi` = 0x00000000, `lo` = 0x0000000F.
- `a` = −7 (0xFFFFFFF9), `b` = 6 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFD6.
- `a` = `b` = 0x80000000 → `hi` = 0x40000000, `lo` = 0x00000000. Exercises the subtract-overflow path and the true-sign logic.
- `a` = 0x80000000, `b` = 0xFFFFFFFF → `hi` = 0x00000000, `lo` = 0x80000000.
- `start` pulsed at cycle 10 of a run with new operands → ignored; the first product completes unchanged. Then hold `start` through DONE → second op accepted at E33 with no idle cycle.
- `clear_n` low at cycle 15 of a run → `busy`, `done`, `hi`, `lo` = 0 immediately, with no `done` afterwards. With `MUL_ABORT_EN`: `abort` at cycle 20 → IDLE, `hi`/`lo` = 0, no `done`.

Source files
------------

// File: rtl/mul_booth_seq_if.sv
// Purpose: bundles the request/result handshake and the shared-adder operand/sum bus of mul_booth_seq.
// Latency: n/a (wires only); the adder side is purely combinational within one cycle.
// Backpressure: none; start is only honoured by the multiplier in IDLE or DONE. Abort exists only with MUL_ABORT_EN.
interface mul_booth_seq_if #(
   parameter int WIDTH = 32
);
   // request / result side
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MUL_ABORT_EN
   logic             abort;
`endif

   // shared carry-lookahead adder side
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_z;
   logic             add_cout;

   // multiplier view: consumes requests and adder results, drives adder operands and results
   modport slave (
      input  start, a, b, add_z, add_cout,
`ifdef MUL_ABORT_EN
      input  abort,
`endif
      output busy, done, hi, lo, add_a, add_b, add_cin
   );

   // requester / environment view (also where the adder lives)
   modport master (
      output start, a, b, add_z, add_cout,
`ifdef MUL_ABORT_EN
      output abort,
`endif
      input  busy, done, hi, lo, add_a, add_b, add_cin
   );
endinterface

// File: rtl/mul_booth_seq.sv
// Purpose: sequential radix-2 Booth multiplier, 32x32 signed -> 64-bit HI/LO, using an external shared adder; optional abort via MUL_ABORT_EN.
// Latency: accept at E0, 32 iterations E1..E32, done pulses for the one cycle after E32; back-to-back accept at E33.
// Backpressure: none; start is ignored while busy, and the caller may hold start through DONE to chain operations.
module mul_booth_seq #(
   parameter int WIDTH = 32
) (
   input  logic           clock,
   input  logic           clear_n,
   mul_booth_seq_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   logic [1:0]       state;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [CW-1:0]    count;

   logic             run;
   logic             accept;
   logic             stop;
   logic             sgn;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;

   assign run    = (state == ST_RUN);
   assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

`ifdef MUL_ABORT_EN
   assign stop = bus.abort;
`else
   assign stop = 1'b0;
`endif

   // Booth recode of {Q[0], q_1}: pick 0, +M or -M (as ~M with carry-in) for the shared adder.
   always_comb begin
      op_b   = '0;
      op_cin = 1'b0;
      if (run) begin
         case ({q[0], q_1})
            2'b01: begin
               op_b   = m;
               op_cin = 1'b0;
            end
            2'b10: begin
               op_b   = ~m;
               op_cin = 1'b1;
            end
            default: begin
               op_b   = '0;
               op_cin = 1'b0;
            end
         endcase
      end
   end

   // Bit 32 of the exact sum, rebuilt from operand signs and carry-out; shifting this in
   // instead of add_z[31] keeps the result correct even when the 32-bit add overflows.
   assign sgn = acc[WIDTH-1] ^ op_b[WIDTH-1] ^ bus.add_cout;

   // Control: IDLE/DONE accept a start, RUN counts 32 iterations (or aborts), DONE lasts one cycle.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (stop)               state <= ST_IDLE;
               else if (count == LAST) state <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.start) state <= ST_RUN;
               else           state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: load operands on accept, then arithmetic right shift of {sgn, sum, Q, q_1} each RUN cycle.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m     <= '0;
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         count <= '0;
      end else if (accept) begin
         m     <= bus.a;
         q     <= bus.b;
         acc   <= '0;
         q_1   <= 1'b0;
         count <= '0;
      end else if (run && stop) begin
         // abandoned run: discard the partial product, keep M (it is never observed outside RUN)
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         count <= '0;
      end else if (run) begin
         acc   <= {sgn, bus.add_z[WIDTH-1:1]};
         q     <= {bus.add_z[0], q[WIDTH-1:1]};
         q_1   <= q[0];
         count <= count + 1'b1;
      end
   end

   // The adder always sees HI as its A operand; results hold until the next accept.
   assign bus.add_a   = acc;
   assign bus.add_b   = op_b;
   assign bus.add_cin = op_cin;
   assign bus.busy    = run;
   assign bus.done    = (state == ST_DONE);
   assign bus.hi      = acc;
   assign bus.lo      = q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Purpose: randomized + directed scoreboard bench for mul_booth_seq with a behavioural adder and product model.
// Latency: expects done exactly 32 cycles after each accept.
// Backpressure: drives start only when not busy, except for deliberate ignored/held-start cases.
module tb_mul_booth_seq;

   logic clock   = 1'b0;
   logic clear_n = 1'b0;

   always #5 clock = ~clock;

   mul_booth_seq_if #(.WIDTH(32)) bus ();

   mul_booth_seq #(.WIDTH(32)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   // shared adder stand-in: plain 33-bit addition
   logic [32:0] sum33;
   assign sum33        = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};
   assign bus.add_z    = sum33[31:0];
   assign bus.add_cout = sum33[32];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          acc;
   } op_t;

   op_t sbq[$];
   int  compared   = 0;
   int  mismatched = 0;
   int  cyc        = 0;
   logic prev_done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on done, checks recode legality while running
   always @(negedge clock) begin
      op_t         e;
      logic [31:0] mm;
      logic        ok;
      if (!clear_n) begin
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("done_width", {63'b0, bus.done}, 64'd0);
         prev_done = bus.done;
         if (bus.done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 64'd1, 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("product", {bus.hi, bus.lo}, ref_mul(e.a, e.b));
               chk("latency", 64'(cyc - e.acc), 64'd32);
               chk("busy_in_done", {63'b0, bus.busy}, 64'd0);
            end
         end else if (bus.busy && sbq.size() > 0) begin
            mm = sbq[0].a;
            ok = ((bus.add_b == 32'd0) && !bus.add_cin) ||
                 ((bus.add_b == mm)    && !bus.add_cin) ||
                 ((bus.add_b == ~mm)   &&  bus.add_cin);
            chk("recode", {63'b0, ok}, 64'd1);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (bus.busy) chk("wait_ready_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (sbq.size() > 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y, output int acc);
      op_t e;
      wait_ready();
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      acc       = cyc + 1;
      e.a = x; e.b = y; e.acc = acc;
      sbq.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
      chk("busy_after_accept", {63'b0, bus.busy}, 64'd1);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"},    {63'b0, bus.busy},    64'd0);
      chk({tag, "_done"},    {63'b0, bus.done},    64'd0);
      chk({tag, "_hilo"},    {bus.hi, bus.lo},     64'd0);
      chk({tag, "_add_b"},   {32'b0, bus.add_b},   64'd0);
      chk({tag, "_add_cin"}, {63'b0, bus.add_cin}, 64'd0);
   endtask

   logic [31:0] dir_a [4] = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] dir_b [4] = '{32'd5, 32'd6,         32'h8000_0000, 32'hFFFF_FFFF};
   logic [63:0] dir_e [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFD6,
                              64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000};
   logic [31:0] special [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1,
                                32'h7FFF_FFFF, 32'h5555_5555};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1);
   end

   initial begin
      int          acc;
      int          acc1;
      logic [31:0] x, y;
      op_t         e;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
`ifdef MUL_ABORT_EN
      bus.abort = 1'b0;
`endif

      // reset state
      repeat (3) @(negedge clock);
      chk_zero("reset");
      clear_n = 1'b1;
      @(negedge clock);

      // directed vectors with hand-computed products
      for (int i = 0; i < 4; i++) begin
         do_op(dir_a[i], dir_b[i], acc);
         drain();
         chk("directed", {bus.hi, bus.lo}, dir_e[i]);
      end

      // results hold after returning to IDLE; adder operand B idle at 0
      repeat (5) @(negedge clock);
      chk("hold_idle", {bus.hi, bus.lo}, dir_e[3]);
      chk("idle_add_b", {32'b0, bus.add_b}, 64'd0);

      // start mid-run ignored, then held start chains with no idle gap
      do_op(32'h1234_5678, 32'hFEDC_BA98, acc1);
      while (cyc < acc1 + 10) @(negedge clock);
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'h0BAD_F00D;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      while (cyc < acc1 + 20) @(negedge clock);
      bus.a     = 32'hFFFF_0003;
      bus.b     = 32'h0001_7FFF;
      bus.start = 1'b1;
      e.a = 32'hFFFF_0003; e.b = 32'h0001_7FFF; e.acc = acc1 + 33;
      sbq.push_back(e);
      while (cyc < acc1 + 33) @(negedge clock);
      bus.start = 1'b0;
      chk("b2b_busy", {63'b0, bus.busy}, 64'd1);
      drain();

      // randomized operations, some chained straight out of DONE
      for (int i = 0; i < 24; i++) begin
         x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         do_op(x, y, acc);
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      drain();

      // asynchronous clear mid-run
      do_op($urandom, $urandom, acc);
      while (cyc < acc + 15) @(negedge clock);
      #2;
      clear_n = 1'b0;
      sbq.delete();
      #1;
      chk_zero("clear");
      repeat (3) @(negedge clock);
      clear_n = 1'b1;
      repeat (40) @(negedge clock);
      chk("clear_after_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("clear_after_busy", {63'b0, bus.busy}, 64'd0);
      do_op(32'hFFFF_FFFE, 32'd21, acc);
      drain();

`ifdef MUL_ABORT_EN
      // abort mid-run
      do_op($urandom, $urandom, acc);
      while (cyc < acc + 20) @(negedge clock);
      bus.abort = 1'b1;
      sbq.delete();
      @(negedge clock);
      bus.abort = 1'b0;
      chk("abort_busy", {63'b0, bus.busy}, 64'd0);
      chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      repeat (40) @(negedge clock);
      chk("abort_idle_busy", {63'b0, bus.busy}, 64'd0);
      // abort outside RUN has no effect
      do_op(32'd1000, 32'hFFFF_FF00, acc);
      drain();
      bus.abort = 1'b1;
      repeat (2) @(negedge clock);
      bus.abort = 1'b0;
      chk("abort_idle_hold", {bus.hi, bus.lo}, ref_mul(32'd1000, 32'hFFFF_FF00));
`endif

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
